spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 10 +
 rtl/spi_sync_edge.sv | 43 ++++
 rtl/spi_slave.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave: FSM encoding and synchronizer depth.
package spi_slave_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    localparam int unsigned STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE   = 1'b0;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall strobes on the synchronized level.
// Strobes are masked until the chain has flushed after reset, so a line that
// is already active at reset release does not produce a spurious edge.
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter logic P_RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned FLUSH_W   = $clog2(SYNC_DEPTH + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_DEPTH + 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;
    logic [FLUSH_W-1:0]    flush_q;
    logic                  level;

    // Synchronizer chain, previous-level flop and post-reset flush counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= {SYNC_DEPTH{P_RST_VAL}};
            prev_q  <= P_RST_VAL;
            flush_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], i_async};
            prev_q <= sync_q[SYNC_DEPTH-1];
            if (flush_q != FLUSH_DONE) begin
                flush_q <= flush_q + FLUSH_W'(1);
            end
        end
    end

    assign level    = sync_q[SYNC_DEPTH-1];
    assign o_rise_c = (flush_q == FLUSH_DONE) &&  level && !prev_q;
    assign o_fall_c = (flush_q == FLUSH_DONE) && !level &&  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all modes via P_CPOL/P_CPHA, with a one-word transmit buffer.
// SPI pins are oversampled in the i_clk domain.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_CPOL       = 0,
    parameter int unsigned P_CPHA       = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_spi_clk,
    input  logic                    i_spi_cs,
    input  logic                    i_spi_mosi,
    output logic                    o_spi_miso,
    output logic                    o_spi_miso_oe,
    input  logic [P_DATA_WIDTH-1:0] i_user_data,
    input  logic                    i_user_valid,
    output logic                    o_ready,
    output logic [P_DATA_WIDTH-1:0] o_user_data,
    output logic                    o_user_valid
);

    localparam int unsigned W     = P_DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
    logic lead_c, trail_c, sample_c, shift_c;
    logic [SYNC_DEPTH-1:0] mosi_q;
    logic mosi_s;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       rx_q, rx_d;
    logic [W-1:0]       tx_q, tx_d;
    logic [W-1:0]       buf_q, buf_d;
    logic               ready_q, ready_d;
    logic [W-1:0]       rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic               wr_c, word_start_c;

    spi_sync_edge #(.P_RST_VAL(1'(P_CPOL))) u_sclk_sync (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_async  (i_spi_clk),
        .o_rise_c (sclk_rise_c),
        .o_fall_c (sclk_fall_c)
    );

    spi_sync_edge #(.P_RST_VAL(1'b1)) u_cs_sync (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_async  (i_spi_cs),
        .o_rise_c (cs_rise_c),
        .o_fall_c (cs_fall_c)
    );

    // MOSI level synchronizer; no edge detection needed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_DEPTH-2:0], i_spi_mosi};
        end
    end

    assign mosi_s   = mosi_q[SYNC_DEPTH-1];
    assign lead_c   = (P_CPOL == 0) ? sclk_rise_c : sclk_fall_c;
    assign trail_c  = (P_CPOL == 0) ? sclk_fall_c : sclk_rise_c;
    assign sample_c = (P_CPHA == 0) ? lead_c  : trail_c;
    assign shift_c  = (P_CPHA == 0) ? trail_c : lead_c;
    assign wr_c     = i_user_valid && ready_q;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            buf_q    <= '0;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            buf_q    <= buf_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
        end
    end

    // Next-state, receive/transmit shifting and buffer handshake
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        buf_d        = buf_q;
        ready_d      = ready_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        word_start_c = 1'b0;

        if (wr_c) begin
            buf_d   = i_user_data;
            ready_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_d      = ST_ACTIVE;
                    cnt_d        = '0;
                    word_start_c = (P_CPHA == 0);
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_c) begin
                    // partial word dropped; transmit buffer left untouched
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rx_d    = '0;
                end else begin
                    if (sample_c) begin
                        rx_d = {rx_q[W-2:0], mosi_s};
                        if (cnt_q == CNT_LAST) begin
                            cnt_d    = '0;
                            rdata_d  = rx_d;
                            rvalid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    // a shift edge with the counter at zero opens a new word
                    if (shift_c) begin
                        if (cnt_q == '0) begin
                            word_start_c = 1'b1;
                        end else begin
                            tx_d = {tx_q[W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // load from the buffer as it stood this cycle; a same-cycle write is kept
        if (word_start_c) begin
            tx_d = ready_q ? '0 : buf_q;
            if (!wr_c) begin
                ready_d = 1'b1;
            end
        end

        oe_d   = (state_d == ST_ACTIVE);
        miso_d = oe_d ? tx_d[W-1] : 1'b0;
    end

    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = oe_q;
    assign o_ready       = ready_q;
    assign o_user_data   = rdata_q;
    assign o_user_valid  = rvalid_q;

endmodule
